// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution sequencer.
package conv_pkg;

    // Sequencer states, from request through completion.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    // Width helper that never returns zero, so degenerate sizes still get a 1-bit field.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_N       = 4;
    localparam int DEF_K       = 3;
    localparam int DEF_MAC_LAT = 1;
    localparam int DEF_IDX_W   = $clog2(DEF_N);
    localparam int DEF_O_W     = clog2_min1((DEF_N - DEF_K + 1) * (DEF_N - DEF_K + 1));

    // Drain counter width, large enough for the deepest supported MAC latency (4).
    localparam int DRAIN_W = 3;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Control/datapath bundle between the top-level controller, the sequencer and the memory/MAC block.
interface conv_seq_ctrl_if
    import conv_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int O_W   = DEF_O_W
) ();

    logic             start;
    logic             hold;
    logic             load_en;
    logic [IDX_W-1:0] a_row;
    logic [IDX_W-1:0] a_col;
    logic [IDX_W-1:0] b_row;
    logic [IDX_W-1:0] b_col;
    logic             mac_en;
    logic             acc_clr;
    logic             out_valid;
    logic [O_W-1:0]   out_idx;
    logic             busy;
    logic             done;

    // Requesting side: issues start/hold and observes the schedule.
    modport master (
        output start, hold,
        input  load_en, a_row, a_col, b_row, b_col, mac_en, acc_clr,
        input  out_valid, out_idx, busy, done
    );

    // Sequencer side: consumes start/hold and drives the schedule.
    modport slave (
        input  start, hold,
        output load_en, a_row, a_col, b_row, b_col, mac_en, acc_clr,
        output out_valid, out_idx, busy, done
    );

endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that retimes the last-tap marker to when the MAC result is ready.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    // Shift every cycle regardless of stalls; the MAC pipeline itself never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for one valid 2-D convolution: load pulse, tap walk over every window, drain, done.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int K       = DEF_K,
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int IDX_W   = $clog2(N),
    parameter int O_W     = clog2_min1((N - K + 1) * (N - K + 1))
) (
    input  logic           clk,
    input  logic           rst,
    conv_seq_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0]   K_LAST     = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0]   O_LAST     = IDX_W'(N - K);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

    state_t state, state_n;

    // Position of the next tap to issue, plus the raster index of its window.
    logic [IDX_W-1:0]   oy, ox, ky, kx;
    logic [IDX_W-1:0]   oy_n, ox_n, ky_n, kx_n;
    logic [O_W-1:0]     win, win_n;
    logic               all_issued, all_issued_n;
    logic [DRAIN_W-1:0] drain_cnt, drain_cnt_n;
    logic               issue;

    // Registered outputs and the window tag of the tap currently presented.
    logic             load_en_q, mac_en_q, acc_clr_q, busy_q, done_q;
    logic             load_en_n, mac_en_n, acc_clr_n, busy_n, done_n;
    logic [IDX_W-1:0] a_row_q, a_col_q, b_row_q, b_col_q;
    logic [IDX_W-1:0] a_row_n, a_col_n, b_row_n, b_col_n;
    logic [O_W-1:0]   tap_win_q, tap_win_n;

    logic             last_tap;
    logic [O_W:0]     dl_in, dl_out;

    // Next-state and next-output decode; a tap is issued from LOAD unconditionally and from COMPUTE when not stalled.
    always_comb begin
        state_n      = state;
        oy_n         = oy;
        ox_n         = ox;
        ky_n         = ky;
        kx_n         = kx;
        win_n        = win;
        all_issued_n = all_issued;
        drain_cnt_n  = drain_cnt;
        load_en_n    = 1'b0;
        mac_en_n     = 1'b0;
        acc_clr_n    = 1'b0;
        done_n       = 1'b0;
        a_row_n      = a_row_q;
        a_col_n      = a_col_q;
        b_row_n      = b_row_q;
        b_col_n      = b_col_q;
        tap_win_n    = tap_win_q;
        issue        = 1'b0;

        case (state)
            IDLE: begin
                a_row_n      = '0;
                a_col_n      = '0;
                b_row_n      = '0;
                b_col_n      = '0;
                tap_win_n    = '0;
                oy_n         = '0;
                ox_n         = '0;
                ky_n         = '0;
                kx_n         = '0;
                win_n        = '0;
                all_issued_n = 1'b0;
                drain_cnt_n  = '0;
                if (bus.start) begin
                    state_n   = LOAD;
                    load_en_n = 1'b1;
                end
            end
            LOAD: begin
                state_n = COMPUTE;
                issue   = 1'b1;
            end
            COMPUTE: begin
                if (all_issued) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else if (!bus.hold) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    drain_cnt_n = drain_cnt + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_n   = IDLE;
                a_row_n   = '0;
                a_col_n   = '0;
                b_row_n   = '0;
                b_col_n   = '0;
                tap_win_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (issue) begin
            a_row_n   = oy + ky;
            a_col_n   = ox + kx;
            b_row_n   = ky;
            b_col_n   = kx;
            mac_en_n  = 1'b1;
            acc_clr_n = (ky == '0) && (kx == '0);
            tap_win_n = win;
            if (kx == K_LAST) begin
                kx_n = '0;
                if (ky == K_LAST) begin
                    ky_n  = '0;
                    win_n = win + O_W'(1);
                    if (ox == O_LAST) begin
                        ox_n = '0;
                        if (oy == O_LAST) begin
                            oy_n         = '0;
                            all_issued_n = 1'b1;
                        end else begin
                            oy_n = oy + IDX_W'(1);
                        end
                    end else begin
                        ox_n = ox + IDX_W'(1);
                    end
                end else begin
                    ky_n = ky + IDX_W'(1);
                end
            end else begin
                kx_n = kx + IDX_W'(1);
            end
        end

        busy_n = (state_n != IDLE);
    end

    // State, counters and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            oy         <= '0;
            ox         <= '0;
            ky         <= '0;
            kx         <= '0;
            win        <= '0;
            all_issued <= 1'b0;
            drain_cnt  <= '0;
            load_en_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_row_q    <= '0;
            a_col_q    <= '0;
            b_row_q    <= '0;
            b_col_q    <= '0;
            tap_win_q  <= '0;
        end else begin
            state      <= state_n;
            oy         <= oy_n;
            ox         <= ox_n;
            ky         <= ky_n;
            kx         <= kx_n;
            win        <= win_n;
            all_issued <= all_issued_n;
            drain_cnt  <= drain_cnt_n;
            load_en_q  <= load_en_n;
            mac_en_q   <= mac_en_n;
            acc_clr_q  <= acc_clr_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            a_row_q    <= a_row_n;
            a_col_q    <= a_col_n;
            b_row_q    <= b_row_n;
            b_col_q    <= b_col_n;
            tap_win_q  <= tap_win_n;
        end
    end

    // The tap on the bus this cycle closes its window when both filter selects are at their last value.
    assign last_tap = mac_en_q && (b_row_q == K_LAST) && (b_col_q == K_LAST);
    assign dl_in    = {last_tap, last_tap ? tap_win_q : {O_W{1'b0}}};

    valid_delay_line #(
        .DEPTH (MAC_LAT),
        .W     (1 + O_W)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign bus.load_en   = load_en_q;
    assign bus.a_row     = a_row_q;
    assign bus.a_col     = a_col_q;
    assign bus.b_row     = b_row_q;
    assign bus.b_col     = b_col_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = dl_out[O_W];
    assign bus.out_idx   = dl_out[O_W-1:0];

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: memory + MAC model, scenario table, random stalls and reset corner cases.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int N          = 4;
    localparam int K          = 3;
    localparam int MAC_LAT    = 1;
    localparam int NW         = N - K + 1;
    localparam int KK         = K * K;
    localparam int TAPS       = NW * NW * KK;
    localparam int IDX_W      = $clog2(N);
    localparam int O_W        = clog2_min1(NW * NW);
    localparam int RUN_CYCLES = 90;

    typedef struct {
        int hold_at;
        int hold_len;
        int hold2_at;
        int hold2_len;
        int start2_at;
        int rand_hold;
        int exp_extra;
        int exp_valids;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_seq_ctrl_if #(.IDX_W(IDX_W), .O_W(O_W)) bus ();

    conv_seq_ctrl #(
        .N       (N),
        .K       (K),
        .MAC_LAT (MAC_LAT),
        .IDX_W   (IDX_W),
        .O_W     (O_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int a_mem [N][N];
    int b_mem [K][K];

    int cyc, n_load, n_mac, n_valid, n_done, n_busy;
    int first_mac, last_mac, last_valid, done_cyc;
    int acc;
    int walk_row [KK];
    int walk_col [KK];
    logic [31:0] quiet;

    vec_t vecs [6];
    int   holds;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Direct convolution of one output window from the bench's own memory images.
    function automatic int ref_conv(input int w);
        int oy, ox, s;
        oy = w / NW;
        ox = w % NW;
        s  = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                s += a_mem[oy+ky][ox+kx] * b_mem[ky][kx];
        return s;
    endfunction

    // Expected selects of the t-th tap in raster window order, kx fastest.
    function automatic logic [31:0] tap_sel(input int t);
        int w, r, oy, ox, ky, kx;
        w  = t / KK;
        r  = t % KK;
        oy = w / NW;
        ox = w % NW;
        ky = r / K;
        kx = r % K;
        return 32'(((oy + ky) << 24) | ((ox + kx) << 16) | (ky << 8) | kx);
    endfunction

    function automatic logic [31:0] bus_sel();
        return (32'(bus.a_row) << 24) | (32'(bus.a_col) << 16) | (32'(bus.b_row) << 8) | 32'(bus.b_col);
    endfunction

    task automatic clear_stats();
        cyc = 0; n_load = 0; n_mac = 0; n_valid = 0; n_done = 0; n_busy = 0;
        first_mac = 0; last_mac = 0; last_valid = 0; done_cyc = 0; acc = 0;
    endtask

    // Monitor: memory + MAC model and per-cycle checks, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.busy) n_busy++;
        if (bus.load_en) n_load++;
        if (!bus.busy) begin
            quiet = 32'({bus.load_en, bus.mac_en, bus.acc_clr, bus.out_valid, bus.done,
                         bus.a_row, bus.a_col, bus.b_row, bus.b_col, bus.out_idx});
            check_output("idle_quiet", quiet, 32'd0);
        end
        if (bus.busy && !bus.mac_en && n_mac > 0 && n_mac < TAPS) begin
            check_output("hold_frozen_sel", bus_sel(), tap_sel(n_mac - 1));
            check_output("hold_acc_clr", 32'(bus.acc_clr), 32'd0);
        end
        if (bus.out_valid) begin
            check_output("out_idx", 32'(bus.out_idx), 32'(n_valid));
            if (n_valid < NW * NW) check_output("result", 32'(acc), 32'(ref_conv(n_valid)));
            n_valid++;
            last_valid = cyc;
        end
        if (bus.mac_en) begin
            check_output("tap_sel", bus_sel(), tap_sel(n_mac));
            check_output("tap_acc_clr", 32'(bus.acc_clr), 32'((n_mac % KK) == 0));
            if (bus.b_row < K && bus.b_col < K) begin
                if (bus.acc_clr) acc = a_mem[bus.a_row][bus.a_col] * b_mem[bus.b_row][bus.b_col];
                else             acc = acc + a_mem[bus.a_row][bus.a_col] * b_mem[bus.b_row][bus.b_col];
            end
            if (n_mac >= TAPS - KK && n_mac < TAPS) begin
                walk_row[n_mac - (TAPS - KK)] = int'(bus.a_row);
                walk_col[n_mac - (TAPS - KK)] = int'(bus.a_col);
            end
            if (n_mac == 0) first_mac = cyc;
            last_mac = cyc;
            n_mac++;
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Drives one run from an idle negedge: start pulse, optional holds and optional second start.
    task automatic apply_stimulus(input vec_t v, output int n_holds);
        int c;
        logic h;
        n_holds = 0;
        for (int k = 0; k < RUN_CYCLES; k++) begin
            c = k - 1;
            bus.start = (k == 0) || (v.start2_at > 0 && c == v.start2_at);
            h = 1'b0;
            if (v.hold_at > 0 && c >= v.hold_at && c < v.hold_at + v.hold_len) h = 1'b1;
            if (v.hold2_at > 0 && c >= v.hold2_at && c < v.hold2_at + v.hold2_len) h = 1'b1;
            if (v.rand_hold != 0 && c >= 1 && c <= 20) h = 1'($urandom_range(0, 1));
            bus.hold = h;
            if (h) n_holds++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    task automatic check_run(input vec_t v, input int extra);
        check_output("load_pulses", 32'(n_load), 32'd1);
        check_output("tap_count", 32'(n_mac), 32'(TAPS));
        check_output("valid_count", 32'(n_valid), 32'(v.exp_valids));
        check_output("done_count", 32'(n_done), 32'd1);
        check_output("compute_len", 32'(last_mac - first_mac + 1), 32'(TAPS + extra));
        check_output("done_after_valid", 32'(done_cyc), 32'(last_valid + 1));
        check_output("busy_span", 32'(n_busy), 32'(1 + TAPS + extra + MAC_LAT + 1));
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                a_mem[r][c] = r * N + c + 1;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                b_mem[r][c] = N * N + r * K + c + 1;

        //            hold_at len hold2 len start2 rand extra valids
        vecs[0] = '{0,  0, 0,  0, 0,  0, 0, 4};
        vecs[1] = '{12, 5, 32, 2, 0,  0, 7, 4};
        vecs[2] = '{0,  0, 0,  0, 10, 0, 0, 4};
        vecs[3] = '{0,  0, 0,  0, 0,  1, 0, 4};
        vecs[4] = '{0,  0, 0,  0, 0,  1, 0, 4};
        vecs[5] = '{0,  0, 0,  0, 0,  1, 0, 4};

        bus.start = 1'b0;
        bus.hold  = 1'b0;
        rst       = 1'b1;
        clear_stats();

        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        clear_stats();
        repeat (5) @(negedge clk);
        check_output("idle_busy_cycles", 32'(n_busy), 32'd0);
        check_output("idle_loads", 32'(n_load), 32'd0);
        check_output("idle_taps", 32'(n_mac), 32'd0);

        for (int i = 0; i < 6; i++) begin
            clear_stats();
            apply_stimulus(vecs[i], holds);
            check_run(vecs[i], (vecs[i].rand_hold != 0) ? holds : vecs[i].exp_extra);
        end

        for (int i = 0; i < KK; i++) begin
            check_output("walk_a_row", 32'(walk_row[i]), 32'(1 + i / K));
            check_output("walk_a_col", 32'(walk_col[i]), 32'(1 + i % K));
        end

        clear_stats();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_mac_en", 32'(bus.mac_en), 32'd0);
        check_output("abort_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_output("abort_no_done", 32'(n_done), 32'd0);
        check_output("abort_valids", 32'(n_valid), 32'd2);

        clear_stats();
        apply_stimulus(vecs[0], holds);
        check_run(vecs[0], 0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
